// File: rtl/draw_cursor.sv
// Plus-shaped cursor overlay: restores the pixels under the previous cursor, saves the
// pixels under the new position, then draws the cursor colour, one slot per cycle.
module draw_cursor #(
    parameter int W_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            in_x,
    input  logic [7:0]            in_y,
    input  logic [7:0]            cursor_color,
    input  logic                  paint,
    input  logic [7:0]            px_data,
    input  logic [7:0]            mem_rdata,
    output logic [2*W_BITS-1:0]   mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [2:0] {IDLE, RESTORE, READ, READ_LAST, DRAW, DONE} state_e;

    localparam logic signed [8:0] MAX_C = 9'((1 << W_BITS) - 1);

    state_e      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic        saved_valid_q;
    logic [7:0]  old_x_q, old_y_q, new_x_q, new_y_q, color_q;
    logic [7:0]  saved_q [5];

    logic              latch, commit, last_slot, clip;
    logic [7:0]        base_x, base_y;
    logic signed [8:0] sx, sy;

    assign last_slot = (slot_q == 3'd4);

    // RESTORE walks the old cursor; READ and DRAW walk the new one.
    always_comb begin
        base_x = (state_q == RESTORE) ? old_x_q : new_x_q;
        base_y = (state_q == RESTORE) ? old_y_q : new_y_q;
        sx = $signed({1'b0, base_x});
        sy = $signed({1'b0, base_y});
        case (slot_q)
            3'd1:    sx = sx - 9'sd1;
            3'd2:    sx = sx + 9'sd1;
            3'd3:    sy = sy - 9'sd1;
            3'd4:    sy = sy + 9'sd1;
            default: ;
        endcase
        clip = (sx < 9'sd0) || (sx > MAX_C) || (sy < 9'sd0) || (sy > MAX_C);
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_wdata = 8'h00;
        mem_addr  = '0;
        latch     = 1'b0;
        commit    = 1'b0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    latch   = 1'b1;
                    slot_d  = 3'd0;
                    state_d = saved_valid_q ? RESTORE : READ;
                end
            end
            RESTORE: begin
                mem_we    = !clip;
                mem_wdata = saved_q[slot_q];
                slot_d    = last_slot ? 3'd0 : slot_q + 3'd1;
                if (last_slot) state_d = READ;
            end
            READ: begin
                mem_re = !clip;
                slot_d = last_slot ? 3'd0 : slot_q + 3'd1;
                if (last_slot) state_d = READ_LAST;
            end
            READ_LAST: state_d = DRAW;
            DRAW: begin
                mem_we    = !clip;
                mem_wdata = color_q;
                slot_d    = last_slot ? 3'd0 : slot_q + 3'd1;
                if (last_slot) begin
                    commit  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (mem_we || mem_re) mem_addr = {sy[W_BITS-1:0], sx[W_BITS-1:0]};
        if (!mem_we) mem_wdata = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            slot_q        <= 3'd0;
            saved_valid_q <= 1'b0;
            old_x_q       <= 8'h00;
            old_y_q       <= 8'h00;
            new_x_q       <= 8'h00;
            new_y_q       <= 8'h00;
            color_q       <= 8'h00;
            for (int i = 0; i < 5; i++) saved_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (latch) begin
                new_x_q <= in_x;
                new_y_q <= in_y;
                color_q <= cursor_color;
            end
            // A paint commit replaces the saved centre so the next restore keeps it.
            if (state_q == IDLE && paint && saved_valid_q) saved_q[0] <= px_data;
            if (state_q == READ && slot_q != 3'd0) saved_q[3'(slot_q - 3'd1)] <= mem_rdata;
            if (state_q == READ_LAST) saved_q[4] <= mem_rdata;
            if (commit) begin
                old_x_q       <= new_x_q;
                old_y_q       <= new_y_q;
                saved_valid_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_draw_cursor.sv
// Directed bench for draw_cursor: framebuffer model, strobe log and latency checks.
module tb_draw_cursor;
    localparam int W = 6;
    typedef logic [20:0] ent_t;   // {we, addr, wdata}; reads log wdata as 0

    logic          clk = 1'b0;
    logic          rst, start, paint;
    logic [7:0]    in_x, in_y, cursor_color, px_data, mem_rdata;
    logic [2*W-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we, mem_re, busy, done;

    logic [7:0]    mem [0:4095];
    ent_t          log_q[$];
    ent_t          e[$];
    int            n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    draw_cursor #(.W_BITS(W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_x(in_x), .in_y(in_y),
        .cursor_color(cursor_color), .paint(paint), .px_data(px_data),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .busy(busy), .done(done)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            chk("strobe_excl", {31'd0, mem_we & mem_re}, 32'd0);
            log_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
        end
    end

    function automatic logic [7:0] pat(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction
    function automatic ent_t wr(input int a, input logic [7:0] d);
        return {1'b1, 12'(a), d};
    endfunction
    function automatic ent_t rd(input int a);
        return {1'b0, 12'(a), 8'h00};
    endfunction

    task automatic chk_seq(input string tag, input ent_t exp[$]);
        chk({tag, "_len"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk($sformatf("%s_%0d", tag, i), {11'd0, log_q[i]}, {11'd0, exp[i]});
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; paint = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE.
    task automatic run_draw(input string tag, input logic [7:0] x, input logic [7:0] y,
                            input logic [7:0] c, input int exp_lat, input int hold);
        int n = 0;
        int s;
        log_q.delete();
        in_x = x; in_y = y; cursor_color = c; start = 1'b1;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            paint = 1'b0;
            if (done) break;
        end
        chk({tag, "_lat"}, n, exp_lat);
        s = log_q.size();
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_done"}, {31'd0, done}, 32'd1);
        end
        if (hold > 0) chk({tag, "_hold_quiet"}, log_q.size(), s);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = pat(i);
        mem_rdata = 8'h00; in_x = 0; in_y = 0; cursor_color = 0; px_data = 0;
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_strobe", {30'd0, mem_we, mem_re}, 32'd0);
        chk("rst_addr", {20'd0, mem_addr}, 32'd0);
        chk("rst_wdata", {24'd0, mem_wdata}, 32'd0);

        // Reset during DRAW slot 2 of a draw at (30,30)
        in_x = 30; in_y = 30; cursor_color = 8'hAA; start = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("abort_we_on", {31'd0, mem_we}, 32'd1);
        chk("abort_addr", {20'd0, mem_addr}, 32'd1951);
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_we_off", {31'd0, mem_we}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // Corner draw: slots 1 and 3 clipped, no restore after the abort
        run_draw("corner", 8'd0, 8'd0, 8'h42, 12, 0);
        e = {rd(0), rd(1), rd(64), wr(0, 8'h42), wr(1, 8'h42), wr(64, 8'h42)};
        chk_seq("corner", e);

        do_reset();
        run_draw("first", 8'd10, 8'd20, 8'hFF, 12, 0);
        e = {rd(1290), rd(1289), rd(1291), rd(1226), rd(1354),
             wr(1290, 8'hFF), wr(1289, 8'hFF), wr(1291, 8'hFF), wr(1226, 8'hFF), wr(1354, 8'hFF)};
        chk_seq("first", e);

        run_draw("move", 8'd11, 8'd20, 8'h11, 17, 0);
        e = {wr(1290, pat(1290)), wr(1289, pat(1289)), wr(1291, pat(1291)),
             wr(1226, pat(1226)), wr(1354, pat(1354)),
             rd(1291), rd(1290), rd(1292), rd(1227), rd(1355),
             wr(1291, 8'h11), wr(1290, 8'h11), wr(1292, 8'h11), wr(1227, 8'h11), wr(1355, 8'h11)};
        chk_seq("move", e);

        run_draw("back", 8'd10, 8'd20, 8'hFF, 17, 0);

        // Paint commit in IDLE, then move: old centre restored with painted colour
        paint = 1'b1; px_data = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        paint = 1'b0;
        run_draw("paint", 8'd12, 8'd20, 8'h22, 17, 0);
        chk("paint_w0", {11'd0, log_q[0]}, {11'd0, wr(1290, 8'h3C)});
        chk("paint_w1", {11'd0, log_q[1]}, {11'd0, wr(1289, pat(1289))});

        // Paint and start together: commit lands before the restore; then hold start
        paint = 1'b1; px_data = 8'h77;
        run_draw("paintst", 8'd12, 8'd21, 8'h33, 17, 20);
        chk("paintst_w0", {11'd0, log_q[0]}, {11'd0, wr(1292, 8'h77)});

        run_draw("redraw", 8'd5, 8'd5, 8'h44, 17, 0);
        chk("redraw_len", log_q.size(), 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/draw_cursor.md
DRAW_CURSOR -- requirements
Module: draw_cursor

Interface
REQ-001 Parameter W_BITS, default 6: log2 of screen width and height (square screen, 2^W_BITS pixels per side).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level request to draw the cursor; held by the controller until done is seen.
REQ-005 in_x, in_y  input  8 each  new cursor centre coordinate; sampled in IDLE when start=1.
REQ-006 cursor_color  input  8  cursor pixel colour; sampled together with in_x/in_y.
REQ-007 paint  input  1  commit strobe from the paint controller; sampled only in IDLE.
REQ-008 px_data  input  8  colour being painted at the current cursor centre; qualifies paint.
REQ-009 mem_rdata  input  8  framebuffer read data; valid the cycle after mem_re=1.
REQ-010 mem_addr  output  2*W_BITS  framebuffer address = {y[W_BITS-1:0], x[W_BITS-1:0]}.
REQ-011 mem_wdata  output  8  framebuffer write data.
REQ-012 mem_we / mem_re  output  1 each  write and read strobes; one-cycle, mutually exclusive.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  high in DONE only.

Function
REQ-015 Cursor shape: a plus of five slots. Slot order: 0 = (x,y), 1 = (x-1,y), 2 = (x+1,y), 3 = (x,y-1), 4 = (x,y+1).
REQ-016 Neighbour coordinates are computed at 9-bit signed width. A slot is clipped if either coordinate is <0 or >2^W_BITS-1.
REQ-017 A clipped slot still consumes its cycle, but mem_we=mem_re=0 in that cycle, so latency is fixed.
REQ-018 State machine: IDLE, RESTORE, READ, READ_LAST, DRAW, DONE. RESTORE, READ and DRAW step a 3-bit slot index from 0 to 4, one slot per cycle.
REQ-019 IDLE with start=1:
- latch in_x, in_y and cursor_color as the new position;
- go to RESTORE if saved_valid=1, else go to READ.
REQ-020 RESTORE slot k: write saved[k] to slot k of the old position (skip if clipped). After slot 4, go to READ.
REQ-021 READ slot k: mem_re=1 at slot k of the new position. The cycle after each slot, mem_rdata is captured into saved[k-1]. After slot 4, go to READ_LAST.
REQ-022 READ_LAST: capture saved[4]; go to DRAW.
REQ-023 DRAW slot k: write cursor_color to slot k of the new position (skip if clipped). After slot 4:
- copy the new position to the old position;
- set saved_valid=1;
- go to DONE.
REQ-024 DONE: done=1; stay in DONE while start=1; go to IDLE on the first cycle start=0. No second draw without a start low-to-high transition.
REQ-025 Latency, counting from the IDLE edge that samples start:
- with saved_valid=1, DONE is entered on cycle 17;
- with saved_valid=0, DONE is entered on cycle 12.
REQ-026 Paint commit: paint=1 in IDLE with saved_valid=1 sets saved[0]<=px_data. Otherwise paint is ignored.
REQ-027 If paint and start are both 1 in IDLE, the commit is applied first, so the RESTORE that follows writes px_data at the old centre.
REQ-028 Saved data of clipped slots is don't-care; it is never written back.
REQ-029 Centre coordinate values >=2^W_BITS clip slot 0; neighbours are evaluated independently.

Reset
REQ-030 rst=1 at a clock edge:
- state=IDLE, slot index=0;
- saved_valid=0;
- old/new position and saved[] cleared to 0;
- busy=done=mem_we=mem_re=0;
- mem_addr=mem_wdata=0.
REQ-031 Reset mid-operation aborts with no further memory strobe from the next cycle. Partial cursor pixels left in the framebuffer are accepted. The next start performs no RESTORE.

Verification
REQ-032 First draw at (10,20), colour 0xFF, W_BITS=6 -> reads at 1290,1289,1291,1226,1354, then writes of 0xFF at the same addresses in the same order; done on cycle 12.
REQ-033 Then start at (11,20) -> five writes of the captured values at 1290,1289,1291,1226,1354 first, then reads/writes at 1291,1290,1292,1227,1355; done on cycle 17.
REQ-034 Draw at (0,0) -> slots 1 and 3 issue no strobe; 3 reads, 3 writes; done still on cycle 12 (or 17).
REQ-035 In IDLE after a draw at (10,20): paint=1, px_data=0x3C; then start at (12,20) -> first RESTORE write is 0x3C at address 1290.
REQ-036 rst pulsed during DRAW slot 2 -> the next cycle has mem_we=0 and busy=0; the next start goes straight to READ (done on cycle 12).
REQ-037 start held high 20 cycles after done -> done stays 1, no memory strobe; start low for 1 cycle then high -> a new draw begins.
